tdp_sram_be: RTL and testbench
==============================

# tdp_sram_be

Parametrised single-clock true dual-port SRAM with per-byte write enables, a selectable read-during-write mode, an optional output pipeline register and a post-reset memory-clear engine. It is the next-generation replacement for the fixed-width dual-port register array in `ip_lib`. Typical users are packet buffers and descriptor tables that need partial-word updates and deterministic contents after reset. Both ports share one clock. Same-cycle write conflicts are resolved deterministically and flagged.

## Interface
- `ADDR_WIDTH`, 4: address bits. DEPTH = 2**ADDR_WIDTH.
- `DATA_WIDTH`, 16: word width. Must be a multiple of 8. BE_WIDTH = DATA_WIDTH/8.
- `RD_MODE`, 0: same-port read-during-write behaviour. 0 = WRITE_FIRST, 1 = READ_FIRST.
- `OUT_REG`, 0: 1 adds an output pipeline stage.
- `CLR_ON_RST`, 1: 1 zero-fills the array after reset.
- `clk`  in  1: single clock; all logic on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `csen_n`  in  1: chip select, active-low, common to both ports.
- `dina` / `dinb`  in  DATA_WIDTH: write data.
- `addra` / `addrb`  in  ADDR_WIDTH: address.
- `bea` / `beb`  in  BE_WIDTH: byte-lane write enable, active-high. Lane i = bits [8i+7:8i].
- `wrena_n` / `wrenb_n`  in  1: write request, active-low.
- `rdena_n` / `rdenb_n`  in  1: read request, active-low.
- `douta` / `doutb`  out  DATA_WIDTH: read data.
- `valida` / `validb`  out  1: `dout` carries data from an access issued LAT cycles earlier.
- `init_busy`  out  1: clear engine active; all port requests are ignored.
- `collision`  out  1: one-cycle pulse marking a same-address dual write.

## Operation
- **FSM states.** INIT and RUN.
  - Reset enters INIT if CLR_ON_RST=1, else RUN.
  - INIT: a counter runs 0..DEPTH-1 and writes all-zero to one address per cycle. After the write of DEPTH-1 the FSM goes to RUN.
  - `init_busy` = 1 exactly while in INIT.
- **Port access (RUN only).** A port is active when `!csen_n && (!wren_n || !rden_n)`.
- **Write.** Applies when `!wren_n`. Only lanes with be[i]=1 are updated. be=0 with `!wren_n` is a no-op write.
- **Read-back.** Any active access returns data after LAT cycles.
  - Read only: the stored word.
  - Write (with or without `!rden_n`), RD_MODE=0: the merged post-write word.
  - Write, RD_MODE=1: the pre-write word.
- **Hold.** With no access, `dout` holds its last value and `valid` = 0.
- **Dual write, same address, same cycle.**
  - Lanes enabled on A take `dina`. Lanes enabled only on B take `dinb`.
  - Each port's read-back follows its own RD_MODE view of the final merged word (RD_MODE=1: old word).
  - `collision` pulses when any lane is enabled on both ports.
- **Cross-port read-during-write, same address.** The reading port returns the pre-write word. No collision flag.
- **Requests during INIT** (including with `csen_n` low) are dropped: no write, `valid` stays 0.

## Timing
- LAT = 1 + OUT_REG. `dout`/`valid` update LAT rising edges after the edge sampling the request. Back-to-back accesses every cycle are supported at full throughput.
- `collision` is registered: high for one cycle, in the cycle after the conflicting edge, independent of OUT_REG.
- **Synchronous reset** (`rst_n` low at an edge) forces:
  - `douta`, `doutb` = 0; `valida`, `validb`, `collision` = 0; pipeline stages cleared; INIT counter = 0.
  - `init_busy` = 1 from the first reset edge if CLR_ON_RST=1, else 0.
  - Array contents are untouched by reset itself.
- **INIT duration.** `init_busy` is high from the first edge with `rst_n` low through DEPTH edges after `rst_n` rises. The first accepted request is at edge DEPTH+1 after release.
- **Reset mid-INIT** restarts the counter at 0. The full DEPTH-cycle clear repeats.
- **Reset mid-pipeline.** In-flight read data is discarded; `valid` is never asserted for pre-reset requests.
- **Counter boundary.** The counter is ADDR_WIDTH+1 bits so DEPTH-1 is detected without wrap. Addresses wrap naturally modulo DEPTH.

## Test plan
- **Reset clear.** Defaults (DEPTH 16), pre-load junk via a prior run, pulse `rst_n` 2 cycles.
  - `init_busy` high for exactly 16 cycles after release.
  - Reads of all 16 addresses return 0x0000, with `valid` 1 cycle after each request.
- **Byte merge.** Write 0xABCD to addr 3 with be=11, then 0x0012 with be=01, then read -> 0xAB12.
- **Read-during-write mode.** addr 5 holds 0x1111. Write 0x2222 with `rdena_n` low.
  - RD_MODE=0 -> `douta` = 0x2222.
  - RD_MODE=1 -> `douta` = 0x1111.
  - Next read -> 0x2222 in both modes.
- **Dual-write collision.** Same edge: A writes 0xAAAA be=01 and B writes 0xBBBB be=11, both to addr 7.
  - `collision` = 1 for one cycle.
  - A later read of addr 7 returns 0xBBAA.
- **Cross-port read during write.** addr 9 holds 0x0F0F. A writes 0xF0F0 while B reads addr 9 on the same edge.
  - `doutb` = 0x0F0F; `collision` = 0.
  - The next B read returns 0xF0F0.
- **Latency and reset mid-INIT.** Set OUT_REG=1 and drive reads every cycle.
  - `valid` and data arrive 2 cycles after each request, with no bubbles.
  - Assert `rst_n` low at INIT count 7: `init_busy` then stays high a full 16 cycles after release, and no `valid` appears for requests issued during INIT.

Source files
------------

// File: rtl/tdp_sram_be.sv
// tdp_sram_be: single-clock true dual-port SRAM with byte enables,
// selectable read-during-write view, optional output register, clear engine.
module tdp_sram_be #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16,
    parameter int RD_MODE    = 0,
    parameter int OUT_REG    = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    csen_n,
    input  logic [DATA_WIDTH-1:0]   dina,
    input  logic [DATA_WIDTH-1:0]   dinb,
    input  logic [ADDR_WIDTH-1:0]   addra,
    input  logic [ADDR_WIDTH-1:0]   addrb,
    input  logic [DATA_WIDTH/8-1:0] bea,
    input  logic [DATA_WIDTH/8-1:0] beb,
    input  logic                    wrena_n,
    input  logic                    wrenb_n,
    input  logic                    rdena_n,
    input  logic                    rdenb_n,
    output logic [DATA_WIDTH-1:0]   douta,
    output logic [DATA_WIDTH-1:0]   doutb,
    output logic                    valida,
    output logic                    validb,
    output logic                    init_busy,
    output logic                    collision
);
    localparam int DEPTH    = 2**ADDR_WIDTH;
    localparam int BE_WIDTH = DATA_WIDTH/8;
    localparam int CW       = ADDR_WIDTH + 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  run, same;
    logic                  act_a, act_b, wr_a, wr_b, coll_c;
    logic [BE_WIDTH-1:0]   we_a, we_b;
    logic [DATA_WIDTH-1:0] old_a, old_b, new_a, new_b, rd_a, rd_b;
    logic [DATA_WIDTH-1:0] d1a, d1b;
    logic                  v1a, v1b;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= (CLR_ON_RST != 0) ? INIT : RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == INIT) begin
            cnt_nxt = cnt + CW'(1);
            if (cnt == CW'(DEPTH - 1)) begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        end
    end

    assign init_busy = (state == INIT);
    assign run       = (state == RUN);

    assign act_a = run && !csen_n && (!wrena_n || !rdena_n);
    assign act_b = run && !csen_n && (!wrenb_n || !rdenb_n);
    assign wr_a  = run && !csen_n && !wrena_n;
    assign wr_b  = run && !csen_n && !wrenb_n;
    assign we_a  = wr_a ? bea : '0;
    assign we_b  = wr_b ? beb : '0;
    assign same  = (addra == addrb);

    assign old_a = mem[addra];
    assign old_b = mem[addrb];

    // On a shared address both ports see the same merged word; A owns shared lanes.
    always_comb begin
        new_a = old_a;
        new_b = old_b;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (we_a[i])
                new_a[8*i +: 8] = dina[8*i +: 8];
            else if (same && we_b[i])
                new_a[8*i +: 8] = dinb[8*i +: 8];
            if (same && we_a[i])
                new_b[8*i +: 8] = dina[8*i +: 8];
            else if (we_b[i])
                new_b[8*i +: 8] = dinb[8*i +: 8];
        end
    end

    assign rd_a   = (RD_MODE == 0 && wr_a) ? new_a : old_a;
    assign rd_b   = (RD_MODE == 0 && wr_b) ? new_b : old_b;
    assign coll_c = wr_a && wr_b && same && |(we_a & we_b);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (init_busy)
                mem[cnt[ADDR_WIDTH-1:0]] <= '0;
            if (wr_b)
                mem[addrb] <= new_b;
            if (wr_a)
                mem[addra] <= new_a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d1a       <= '0;
            d1b       <= '0;
            v1a       <= 1'b0;
            v1b       <= 1'b0;
            collision <= 1'b0;
        end else begin
            v1a       <= act_a;
            v1b       <= act_b;
            collision <= coll_c;
            if (act_a)
                d1a <= rd_a;
            if (act_b)
                d1b <= rd_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    douta  <= '0;
                    doutb  <= '0;
                    valida <= 1'b0;
                    validb <= 1'b0;
                end else begin
                    valida <= v1a;
                    validb <= v1b;
                    if (v1a)
                        douta <= d1a;
                    if (v1b)
                        doutb <= d1b;
                end
            end
        end else begin : g_noreg
            assign douta  = d1a;
            assign doutb  = d1b;
            assign valida = v1a;
            assign validb = v1b;
        end
    endgenerate

endmodule

// File: tb/tb_tdp_sram_be.sv
// tb_tdp_sram_be: randomized and directed checks of two tdp_sram_be builds
// (WRITE_FIRST/no out reg, READ_FIRST/out reg) against a word-array model.
module tb_tdp_sram_be;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        csen_n;
    logic [15:0] dina, dinb;
    logic [3:0]  addra, addrb;
    logic [1:0]  bea, beb;
    logic        wrena_n, wrenb_n, rdena_n, rdenb_n;

    logic [15:0] douta0, doutb0, douta1, doutb1;
    logic        valida0, validb0, busy0, coll0;
    logic        valida1, validb1, busy1, coll1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [15:0] mdl [16];
    int          busy_left = 0;
    logic        hv [2][2][2];
    logic [15:0] hd [2][2][2];
    logic [15:0] ed [2][2];
    logic        ev [2][2];
    logic        ecoll;

    always #5 clk = ~clk;

    tdp_sram_be #(.RD_MODE(0), .OUT_REG(0)) u0 (
        .clk(clk), .rst_n(rst_n), .csen_n(csen_n),
        .dina(dina), .dinb(dinb), .addra(addra), .addrb(addrb),
        .bea(bea), .beb(beb), .wrena_n(wrena_n), .wrenb_n(wrenb_n),
        .rdena_n(rdena_n), .rdenb_n(rdenb_n),
        .douta(douta0), .doutb(doutb0), .valida(valida0), .validb(validb0),
        .init_busy(busy0), .collision(coll0)
    );

    tdp_sram_be #(.RD_MODE(1), .OUT_REG(1)) u1 (
        .clk(clk), .rst_n(rst_n), .csen_n(csen_n),
        .dina(dina), .dinb(dinb), .addra(addra), .addrb(addrb),
        .bea(bea), .beb(beb), .wrena_n(wrena_n), .wrenb_n(wrenb_n),
        .rdena_n(rdena_n), .rdenb_n(rdenb_n),
        .douta(douta1), .doutb(doutb1), .valida(valida1), .validb(validb1),
        .init_busy(busy1), .collision(coll1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic idle();
        csen_n  = 1'b1;
        wrena_n = 1'b1;
        wrenb_n = 1'b1;
        rdena_n = 1'b1;
        rdenb_n = 1'b1;
        bea     = 2'b00;
        beb     = 2'b00;
    endtask

    task automatic opa(input logic [3:0] a, input logic [15:0] d,
                       input logic [1:0] be, input logic wr, input logic rd);
        csen_n  = 1'b0;
        addra   = a;
        dina    = d;
        bea     = be;
        wrena_n = !wr;
        rdena_n = !rd;
    endtask

    task automatic opb(input logic [3:0] a, input logic [15:0] d,
                       input logic [1:0] be, input logic wr, input logic rd);
        csen_n  = 1'b0;
        addrb   = a;
        dinb    = d;
        beb     = be;
        wrenb_n = !wr;
        rdenb_n = !rd;
    endtask

    task automatic rand_req();
        csen_n  = ($urandom_range(0, 7) == 0);
        wrena_n = 1'($urandom_range(0, 1));
        wrenb_n = 1'($urandom_range(0, 1));
        rdena_n = 1'($urandom_range(0, 1));
        rdenb_n = 1'($urandom_range(0, 1));
        addra   = 4'($urandom_range(0, 15));
        addrb   = ($urandom_range(0, 2) == 0) ? addra : 4'($urandom_range(0, 15));
        bea     = 2'($urandom);
        beb     = 2'($urandom);
        dina    = 16'($urandom);
        dinb    = 16'($urandom);
    endtask

    // One clock: model predicts, edge, then compare both builds.
    task automatic step();
        logic [15:0] nm [16];
        logic [15:0] res [2][2];
        logic        act [2];
        logic        wr [2];
        logic [3:0]  ad [2];
        logic [1:0]  be [2];
        logic [15:0] dn [2];
        logic        run, ec;
        ad[0] = addra;  ad[1] = addrb;
        be[0] = bea;    be[1] = beb;
        dn[0] = dina;   dn[1] = dinb;
        run    = rst_n && (busy_left == 0);
        act[0] = run && !csen_n && (!wrena_n || !rdena_n);
        act[1] = run && !csen_n && (!wrenb_n || !rdenb_n);
        wr[0]  = run && !csen_n && !wrena_n;
        wr[1]  = run && !csen_n && !wrenb_n;
        nm = mdl;
        for (int p = 1; p >= 0; p--)
            if (wr[p])
                for (int l = 0; l < 2; l++)
                    if (be[p][l])
                        nm[ad[p]][8*l +: 8] = dn[p][8*l +: 8];
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++)
                res[k][p] = (wr[p] && k == 0) ? nm[ad[p]] : mdl[ad[p]];
        ec = wr[0] && wr[1] && (ad[0] == ad[1]) && |(be[0] & be[1]);

        @(posedge clk);
        #1;

        if (!rst_n) begin
            busy_left = 16;
            ecoll = 1'b0;
            for (int i = 0; i < 16; i++)
                mdl[i] = 16'h0;
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 2; p++) begin
                    hv[k][p][0] = 1'b0;
                    hv[k][p][1] = 1'b0;
                    hd[k][p][0] = 16'h0;
                    hd[k][p][1] = 16'h0;
                    ev[k][p] = 1'b0;
                    ed[k][p] = 16'h0;
                end
        end else begin
            if (busy_left > 0)
                busy_left--;
            mdl = nm;
            ecoll = ec;
            for (int k = 0; k < 2; k++)
                for (int p = 0; p < 2; p++) begin
                    hv[k][p][1] = hv[k][p][0];
                    hd[k][p][1] = hd[k][p][0];
                    hv[k][p][0] = act[p];
                    hd[k][p][0] = res[k][p];
                    ev[k][p] = hv[k][p][k];
                    if (ev[k][p])
                        ed[k][p] = hd[k][p][k];
                end
        end

        chk("u0.douta", douta0, ed[0][0]);
        chk("u0.doutb", doutb0, ed[0][1]);
        chk("u0.valida", valida0, ev[0][0]);
        chk("u0.validb", validb0, ev[0][1]);
        chk("u0.collision", coll0, ecoll);
        chk("u0.init_busy", busy0, busy_left != 0);
        chk("u1.douta", douta1, ed[1][0]);
        chk("u1.doutb", doutb1, ed[1][1]);
        chk("u1.valida", valida1, ev[1][0]);
        chk("u1.validb", validb1, ev[1][1]);
        chk("u1.collision", coll1, ecoll);
        chk("u1.init_busy", busy1, busy_left != 0);
    endtask

    task automatic wait_init(input string tag, input bit rnd);
        int n = 0;
        while (busy0 && n < 40) begin
            if (rnd)
                rand_req();
            step();
            n++;
        end
        chk(tag, n, 16);
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            mdl[i] = 16'h0;
        rst_n = 1'b0;
        idle();
        addra = '0; addrb = '0; dina = '0; dinb = '0;

        repeat (2) step();
        rst_n = 1'b1;
        wait_init("init_len0", 1'b1);

        repeat (400) begin
            rand_req();
            step();
        end

        rst_n = 1'b0;
        repeat (2) begin
            rand_req();
            step();
        end
        rst_n = 1'b1;
        wait_init("init_len1", 1'b1);

        idle();
        for (int i = 0; i < 16; i++) begin
            opa(4'(i), 16'h0, 2'b00, 1'b0, 1'b1);
            step();
            chk("clr_rd", douta0, 16'h0000);
            chk("clr_valid", valida0, 1'b1);
        end

        idle(); opa(4'd3, 16'hABCD, 2'b11, 1'b1, 1'b0); step();
        opa(4'd3, 16'h0012, 2'b01, 1'b1, 1'b0); step();
        opa(4'd3, 16'h0000, 2'b00, 1'b0, 1'b1); step();
        chk("merge_u0", douta0, 16'hAB12);
        idle(); step();
        chk("merge_u1", douta1, 16'hAB12);

        idle(); opa(4'd5, 16'h1111, 2'b11, 1'b1, 1'b0); step();
        opa(4'd5, 16'h2222, 2'b11, 1'b1, 1'b1); step();
        chk("rdw_wfirst", douta0, 16'h2222);
        opa(4'd5, 16'h0000, 2'b00, 1'b0, 1'b1); step();
        chk("rdw_rfirst", douta1, 16'h1111);
        chk("rdw_next0", douta0, 16'h2222);
        idle(); step();
        chk("rdw_next1", douta1, 16'h2222);

        idle();
        opa(4'd7, 16'hAAAA, 2'b01, 1'b1, 1'b0);
        opb(4'd7, 16'hBBBB, 2'b11, 1'b1, 1'b0);
        step();
        chk("coll_u0", coll0, 1'b1);
        chk("coll_u1", coll1, 1'b1);
        idle(); opa(4'd7, 16'h0000, 2'b00, 1'b0, 1'b1); step();
        chk("coll_clr", coll0, 1'b0);
        chk("coll_rd", douta0, 16'hBBAA);

        idle(); opa(4'd9, 16'h0F0F, 2'b11, 1'b1, 1'b0); step();
        opa(4'd9, 16'hF0F0, 2'b11, 1'b1, 1'b0);
        opb(4'd9, 16'h0000, 2'b00, 1'b0, 1'b1);
        step();
        chk("xrd_old", doutb0, 16'h0F0F);
        chk("xrd_nocoll", coll0, 1'b0);
        idle(); opb(4'd9, 16'h0000, 2'b00, 1'b0, 1'b1); step();
        chk("xrd_new", doutb0, 16'hF0F0);
        chk("xrd_old1", doutb1, 16'h0F0F);
        idle(); step();
        chk("xrd_new1", doutb1, 16'hF0F0);

        repeat (300) begin
            rand_req();
            step();
        end

        idle();
        opa(4'd0, 16'h0, 2'b00, 1'b0, 1'b1);
        opb(4'd1, 16'h0, 2'b00, 1'b0, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (7) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        wait_init("init_len_mid", 1'b0);
        for (int j = 0; j < 20; j++) begin
            addra = 4'($urandom_range(0, 15));
            addrb = 4'($urandom_range(0, 15));
            step();
            chk("b2b_v0", valida0, 1'b1);
            chk("b2b_v1", valida1, j > 0);
        end

        idle();
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
